// File: rtl/pll_lock_ctrl.sv
// PLL lock controller: pulses the PLL reset, waits for a qualified lock, then releases
// the downstream system reset. Lock losses and lock timeouts are counted.
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1048576,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] fault_cnt
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Terminal counts; each legal parameter minus one fits in the 24-bit counter.
  localparam logic [23:0] RST_LAST    = 24'(RST_CYCLES - 1);
  localparam logic [23:0] LOCK_LAST   = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] STABLE_LAST = 24'(STABLE_CYCLES - 1);

  state_t      state_reg;
  logic [23:0] cnt_reg;
  logic [7:0]  fault_reg;
  logic        sync_meta_reg;
  logic        locked_s;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_meta_reg <= 1'b0;
      locked_s      <= 1'b0;
    end else begin
      sync_meta_reg <= pll_locked;
      locked_s      <= sync_meta_reg;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg <= RESET_PLL;
      cnt_reg   <= 24'd0;
      fault_reg <= 8'd0;
    end else begin
      case (state_reg)
        RESET_PLL: begin
          if (cnt_reg == RST_LAST) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= 24'd0;
          end else begin
            cnt_reg <= cnt_reg + 24'd1;
          end
        end
        WAIT_LOCK: begin
          // A lock seen on the timeout cycle wins over the timeout.
          if (locked_s) begin
            state_reg <= STABILIZE;
            cnt_reg   <= 24'd0;
          end else if (cnt_reg == LOCK_LAST) begin
            state_reg <= RESET_PLL;
            cnt_reg   <= 24'd0;
            if (fault_reg != 8'hFF) fault_reg <= fault_reg + 8'd1;
          end else begin
            cnt_reg <= cnt_reg + 24'd1;
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= 24'd0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg <= RUN;
            cnt_reg   <= 24'd0;
          end else begin
            cnt_reg <= cnt_reg + 24'd1;
          end
        end
        RUN: begin
          cnt_reg <= 24'd0;
          if (!locked_s) begin
            state_reg <= RESET_PLL;
            if (fault_reg != 8'hFF) fault_reg <= fault_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= RESET_PLL;
          cnt_reg   <= 24'd0;
        end
      endcase
    end
  end

  // Pure decodes of the state register so they follow rst with no clock edge.
  assign pll_rst   = (state_reg == RESET_PLL);
  assign sys_rst   = (state_reg != RUN);
  assign ready     = (state_reg == RUN);
  assign fault_cnt = fault_reg;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8.
// Edge n counts refclk rising edges after rst is released between edges.
module tb_pll_lock_ctrl;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] fault_cnt;

  int checks = 0;
  int errors = 0;

  pll_lock_ctrl #(
    .RST_CYCLES(4),
    .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .fault_cnt(fault_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic tick;
    @(posedge refclk);
    #1;
  endtask

  // Leaves rst released 1 time unit after an edge, so the next edge is edge 1.
  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b110) begin
      errors++;
      $display("FAIL reset_outputs got pll_rst/sys_rst/ready=%b expected 110", {pll_rst, sys_rst, ready});
    end
    checks++;
    if (fault_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_fault got %0d expected 0", fault_cnt);
    end
    pll_locked = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b110) begin
      errors++;
      $display("FAIL reset_held got pll_rst/sys_rst/ready=%b expected 110", {pll_rst, sys_rst, ready});
    end
    $display("test_reset done");
  endtask

  task automatic test_lock_seq;
    pll_locked = 1'b0;
    do_reset();
    for (int n = 1; n <= 22; n++) begin
      pll_locked = (n >= 10);
      tick();
      checks++;
      if (pll_rst !== (n < 4)) begin
        errors++;
        $display("FAIL lock_seq_pll_rst edge %0d got %b expected %b", n, pll_rst, (n < 4));
      end
      checks++;
      if ({ready, sys_rst} !== {(n >= 20), (n < 20)}) begin
        errors++;
        $display("FAIL lock_seq_ready edge %0d got ready/sys_rst=%b%b expected %b%b",
                 n, ready, sys_rst, (n >= 20), (n < 20));
      end
    end
    checks++;
    if (fault_cnt !== 8'd0) begin
      errors++;
      $display("FAIL lock_seq_fault got %0d expected 0", fault_cnt);
    end
    $display("test_lock_seq done");
  endtask

  // Starts in RUN with fault_cnt=0; lock low sampled at edge k.
  task automatic test_lock_loss;
    pll_locked = 1'b0;
    tick();  // k
    tick();  // k+1
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL loss_k1_ready got %b expected 1", ready);
    end
    tick();  // k+2
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b110) begin
      errors++;
      $display("FAIL loss_k2_outputs got pll_rst/sys_rst/ready=%b expected 110", {pll_rst, sys_rst, ready});
    end
    checks++;
    if (fault_cnt !== 8'd1) begin
      errors++;
      $display("FAIL loss_fault got %0d expected 1", fault_cnt);
    end
    pll_locked = 1'b1;
    for (int j = 3; j <= 15; j++) begin
      tick();
      checks++;
      if ({pll_rst, ready} !== {(j <= 5), (j >= 15)}) begin
        errors++;
        $display("FAIL relock edge k+%0d got pll_rst/ready=%b%b expected %b%b",
                 j, pll_rst, ready, (j <= 5), (j >= 15));
      end
    end
    $display("test_lock_loss done");
  endtask

  // From RUN: lose lock (fault 2), relock, then hit rst between edges mid-STABILIZE.
  task automatic test_async_reset;
    pll_locked = 1'b0;
    tick();
    tick();
    tick();
    pll_locked = 1'b1;
    for (int j = 3; j <= 10; j++) tick();
    checks++;
    if ({pll_rst, ready, fault_cnt} !== {1'b0, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL async_pre got pll_rst=%b ready=%b fault=%0d expected 0 0 2", pll_rst, ready, fault_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b110) begin
      errors++;
      $display("FAIL async_outputs got pll_rst/sys_rst/ready=%b expected 110", {pll_rst, sys_rst, ready});
    end
    checks++;
    if (fault_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_fault got %0d expected 0", fault_cnt);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_stabilize_drop;
    pll_locked = 1'b0;
    do_reset();
    for (int n = 1; n <= 41; n++) begin
      pll_locked = (n >= 6 && n <= 10) || (n >= 31);
      tick();
      checks++;
      if ({pll_rst, ready} !== {(n < 4), (n >= 41)}) begin
        errors++;
        $display("FAIL stab_drop edge %0d got pll_rst/ready=%b%b expected %b%b",
                 n, pll_rst, ready, (n < 4), (n >= 41));
      end
    end
    checks++;
    if (fault_cnt !== 8'd0) begin
      errors++;
      $display("FAIL stab_drop_fault got %0d expected 0", fault_cnt);
    end
    $display("test_stabilize_drop done");
  endtask

  // locked_s first high exactly when the WAIT_LOCK counter reads 31.
  task automatic test_timeout_race;
    pll_locked = 1'b0;
    do_reset();
    for (int n = 1; n <= 45; n++) begin
      pll_locked = (n >= 34);
      tick();
      checks++;
      if ({pll_rst, ready} !== {(n < 4), (n >= 44)}) begin
        errors++;
        $display("FAIL race edge %0d got pll_rst/ready=%b%b expected %b%b",
                 n, pll_rst, ready, (n < 4), (n >= 44));
      end
    end
    checks++;
    if (fault_cnt !== 8'd0) begin
      errors++;
      $display("FAIL race_fault got %0d expected 0", fault_cnt);
    end
    $display("test_timeout_race done");
  endtask

  task automatic test_timeouts;
    pll_locked = 1'b0;
    do_reset();
    for (int n = 1; n <= 10800; n++) begin
      tick();
      if (n <= 80) begin
        checks++;
        if (pll_rst !== ((n % 36) < 4)) begin
          errors++;
          $display("FAIL timeout_pll_rst edge %0d got %b expected %b", n, pll_rst, ((n % 36) < 4));
        end
        if ((n % 36) == 0 || (n % 36) == 35) begin
          checks++;
          if (fault_cnt !== 8'(n / 36)) begin
            errors++;
            $display("FAIL timeout_fault edge %0d got %0d expected %0d", n, fault_cnt, n / 36);
          end
        end
      end
      if (n == 255 * 36 - 1 || n == 255 * 36 || n == 10800) begin
        checks++;
        if (fault_cnt !== ((n == 255 * 36 - 1) ? 8'd254 : 8'd255)) begin
          errors++;
          $display("FAIL timeout_saturate edge %0d got %0d expected %0d",
                   n, fault_cnt, (n == 255 * 36 - 1) ? 254 : 255);
        end
      end
    end
    $display("test_timeouts done");
  endtask

  initial begin
    test_reset();
    test_lock_seq();
    test_lock_loss();
    test_async_reset();
    test_stabilize_drop();
    test_timeout_race();
    test_timeouts();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16, pll_rst pulse width in refclk cycles; legal range 1..2^24.
REQ-002 Parameter LOCK_TIMEOUT, default 1048576, max cycles in WAIT_LOCK before PLL re-reset; legal range 1..2^24.
REQ-003 Parameter STABLE_CYCLES, default 1024, cycles pll_locked must stay high before release; legal range 1..2^24.
REQ-004 refclk  in  1  sole clock; all flops on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 pll_locked  in  1  PLL lock indicator, asynchronous to refclk.
REQ-007 pll_rst  out  1  reset to the PLL, active-high.
REQ-008 sys_rst  out  1  downstream system reset, active-high.
REQ-009 ready  out  1  high only while the PLL is lock-qualified.
REQ-010 fault_cnt  out  8  count of lock losses plus lock timeouts.

Function
REQ-011 pll_locked SHALL pass through a 2-flop synchronizer (locked_s) before any use; both flops reset to 0.
REQ-012 FSM states SHALL be RESET_PLL, WAIT_LOCK, STABILIZE, RUN, with a shared 24-bit cycle counter cleared on every state change.
REQ-013 Outputs SHALL be Moore decodes of the state register: pll_rst=(RESET_PLL); sys_rst=(state!=RUN); ready=(RUN).
REQ-014 RESET_PLL: counter increments each cycle; at counter==RST_CYCLES-1 -> WAIT_LOCK; pll_rst high for exactly RST_CYCLES cycles; locked_s ignored.
REQ-015 WAIT_LOCK: locked_s=1 -> STABILIZE; else at counter==LOCK_TIMEOUT-1 -> RESET_PLL and fault_cnt+1; lock takes priority over timeout in the same cycle.
REQ-016 STABILIZE: locked_s=0 -> WAIT_LOCK, no fault increment; else at counter==STABLE_CYCLES-1 -> RUN.
REQ-017 RUN: locked_s=0 -> RESET_PLL and fault_cnt+1; otherwise hold.
REQ-018 Latency: pll_locked first sampled high at edge k and held -> state STABILIZE after edge k+2, ready=1 after edge k+2+STABLE_CYCLES.
REQ-019 Lock loss in RUN: pll_locked sampled low at edge k -> ready=0, sys_rst=1, pll_rst=1 after edge k+2.
REQ-020 fault_cnt SHALL saturate at 255 and clear only on rst.
REQ-021 Lock pulses shorter than one refclk cycle need not be detected; any locked_s change SHALL act per the current state only.

Reset
REQ-022 While rst=1: state=RESET_PLL, counter=0, synchronizer=0, fault_cnt=0, pll_rst=1, sys_rst=1, ready=0, all immediately without a clock edge.
REQ-023 After rst deasserts, pll_rst SHALL stay high for RST_CYCLES further edges; rst mid-operation in any state SHALL abort to REQ-022 values.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8)
REQ-024 rst released, pll_locked high from edge 10 -> pll_rst high 4 cycles then low; ready=1 and sys_rst=0 after edge 20; fault_cnt=0.
REQ-025 pll_locked held 0 -> pll_rst re-pulses 4 cycles every 36 cycles; fault_cnt increments per timeout; after 300 timeouts fault_cnt=255.
REQ-026 pll_locked high 5 cycles then low during STABILIZE -> back to WAIT_LOCK, ready never rises, fault_cnt unchanged, no pll_rst pulse.
REQ-027 In RUN, pll_locked low at edge k -> ready=0, sys_rst=1, pll_rst=1 after edge k+2; fault_cnt=1; relock relaunches full sequence.
REQ-028 Assert rst asynchronously mid-STABILIZE (between edges) -> pll_rst=1, sys_rst=1, ready=0, fault_cnt=0 before the next edge.
REQ-029 Lock arriving on the same cycle as timeout (locked_s rises at WAIT_LOCK counter=31) -> STABILIZE, no fault increment.
